// File: rtl/param_fifo.sv
`timescale 1ns / 1ps
// Single-clock parameterised FIFO with status thresholds, sticky error flags and an
// optional first-word-fall-through read port.
module param_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AE_LEVEL = 4,
    parameter int unsigned AF_LEVEL = 28,
    parameter bit          FWFT     = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic                     clear_err,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] count_s;
    logic          empty_s;
    logic          full_s;
    logic          wr_accept;
    logic          rd_accept;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    // The extra pointer bit makes the difference span 0..DEPTH without ambiguity.
    assign count_s   = wr_ptr_q - rd_ptr_q;
    assign empty_s   = (count_s == '0);
    assign full_s    = (count_s == PW'(DEPTH));
    assign wr_accept = wr_en && !full_s;
    assign rd_accept = rd_en && !empty_s;
    assign wr_addr   = wr_ptr_q[AW-1:0];
    assign rd_addr   = rd_ptr_q[AW-1:0];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (clear_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        // Set after clear so a coincident error wins.
        if (wr_en && full_s) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty_s) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_accept) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    if (FWFT == 1'b0) begin : g_std_read
        logic [WIDTH-1:0] rd_data_q;
        logic             rd_valid_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_accept;
                if (rd_accept) begin
                    rd_data_q <= mem_q[rd_addr];
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_fwft_read
        // Head entry is presented directly; zero while empty keeps the port quiet.
        assign rd_data  = empty_s ? '0 : mem_q[rd_addr];
        assign rd_valid = !empty_s;
    end

    assign count        = count_s;
    assign empty        = empty_s;
    assign full         = full_s;
    assign almost_empty = (count_s <= PW'(AE_LEVEL));
    assign almost_full  = (count_s >= PW'(AF_LEVEL));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
`timescale 1ns / 1ps
// Directed bench for param_fifo: standard-read instance checked through a scoreboard,
// plus a first-word-fall-through instance checked directly.
module tb_param_fifo;

    logic       clk;
    logic       reset, wr_en, rd_en, clear_err;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [5:0] count;

    logic       f_reset, f_wr_en, f_rd_en, f_clear_err;
    logic [7:0] f_wr_data;
    logic [7:0] f_rd_data;
    logic       f_rd_valid, f_empty, f_full, f_almost_empty, f_almost_full;
    logic       f_overflow, f_underflow;
    logic [5:0] f_count;

    logic [7:0] exp_q[$];
    int         n_vec;
    int         n_err;

    param_fifo #(.WIDTH(8), .DEPTH(32), .AE_LEVEL(4), .AF_LEVEL(28), .FWFT(1'b0)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .clear_err    (clear_err),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    param_fifo #(.WIDTH(8), .DEPTH(32), .AE_LEVEL(4), .AF_LEVEL(28), .FWFT(1'b1)) u_dut_fwft (
        .clk          (clk),
        .reset        (f_reset),
        .wr_en        (f_wr_en),
        .wr_data      (f_wr_data),
        .rd_en        (f_rd_en),
        .clear_err    (f_clear_err),
        .rd_data      (f_rd_data),
        .rd_valid     (f_rd_valid),
        .empty        (f_empty),
        .full         (f_full),
        .almost_empty (f_almost_empty),
        .almost_full  (f_almost_full),
        .count        (f_count),
        .overflow     (f_overflow),
        .underflow    (f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pop(input logic [7:0] e);
        rd_en = 1'b1;
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_almost_empty"}, 32'(almost_empty), 32'd1);
        chk({tag, "_almost_full"}, 32'(almost_full), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_underflow"}, 32'(underflow), 32'd0);
    endtask

    // Monitor: every valid read beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rd_valid: got rd_data 0x%0h, required no valid beat",
                         rd_data);
            end else begin
                chk("rd_data_order", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b1;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        clear_err   = 1'b0;
        wr_data     = 8'h00;
        f_reset     = 1'b1;
        f_wr_en     = 1'b0;
        f_rd_en     = 1'b0;
        f_clear_err = 1'b0;
        f_wr_data   = 8'h00;
        tick();
        tick();
        reset   = 1'b0;
        f_reset = 1'b0;
        check_reset_state("rst");
        chk("fwft_rst_rd_valid", 32'(f_rd_valid), 32'd0);
        chk("fwft_rst_rd_data", 32'(f_rd_data), 32'd0);

        // Fill 0x01..0x20, watching thresholds, then drain in order.
        for (int i = 0; i < 32; i++) begin
            push(8'(i + 1));
            chk("fill_count", 32'(count), 32'(i + 1));
            if (i + 1 == 4)  chk("ae_at_4", 32'(almost_empty), 32'd1);
            if (i + 1 == 5)  chk("ae_at_5", 32'(almost_empty), 32'd0);
            if (i + 1 == 27) chk("af_at_27", 32'(almost_full), 32'd0);
            if (i + 1 == 28) chk("af_at_28", 32'(almost_full), 32'd1);
            if (i + 1 == 31) chk("full_at_31", 32'(full), 32'd0);
        end
        chk("full_at_32", 32'(full), 32'd1);
        for (int i = 0; i < 32; i++) begin
            pop(8'(i + 1));
            chk("drain_count", 32'(count), 32'(31 - i));
        end
        chk("empty_after_drain", 32'(empty), 32'd1);

        // Overflow, set-wins, clear, and full write+read collision.
        for (int i = 0; i < 32; i++) push(8'h40 + 8'(i));
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd32);
        wr_en     = 1'b1;
        wr_data   = 8'hAB;
        clear_err = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        tick();
        clear_err = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'hBB;
        rd_en   = 1'b1;
        exp_q.push_back(8'h40);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("full_wr_rd_count", 32'(count), 32'd31);
        chk("full_wr_rd_ovf", 32'(overflow), 32'd1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        for (int i = 1; i < 32; i++) pop(8'h40 + 8'(i));
        chk("empty_after_ovf", 32'(empty), 32'd1);

        // Underflow and empty write+read collision (no bypass).
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("unf_set", 32'(underflow), 32'd1);
        chk("unf_rd_valid", 32'(rd_valid), 32'd0);
        chk("unf_count", 32'(count), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'h77;
        rd_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("empty_wr_rd_count", 32'(count), 32'd1);
        chk("empty_wr_rd_valid", 32'(rd_valid), 32'd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("unf_cleared", 32'(underflow), 32'd0);
        pop(8'h77);

        // Standard-read latency: write in N, rd_en in N+1, data in N+2.
        push(8'h5A);
        chk("lat_empty_n1", 32'(empty), 32'd0);
        pop(8'h5A);
        chk("lat_rd_valid_n2", 32'(rd_valid), 32'd1);
        chk("lat_rd_data_n2", 32'(rd_data), 32'h5A);
        tick();
        chk("lat_rd_hold", 32'(rd_data), 32'h5A);
        chk("lat_rd_valid_drop", 32'(rd_valid), 32'd0);

        // FWFT instance: head visible one cycle after write with no rd_en.
        f_wr_en   = 1'b1;
        f_wr_data = 8'h5A;
        tick();
        f_wr_data = 8'h11;
        tick();
        f_wr_en = 1'b0;
        chk("fwft_valid", 32'(f_rd_valid), 32'd1);
        chk("fwft_head", 32'(f_rd_data), 32'h5A);
        chk("fwft_count", 32'(f_count), 32'd2);
        f_rd_en = 1'b1;
        tick();
        chk("fwft_next_head", 32'(f_rd_data), 32'h11);
        tick();
        f_rd_en = 1'b0;
        chk("fwft_empty_valid", 32'(f_rd_valid), 32'd0);
        chk("fwft_empty", 32'(f_empty), 32'd1);

        // Steady-state streaming at occupancy 16 across several pointer wraps.
        for (int j = 0; j < 16; j++) push(8'(j));
        for (int k = 0; k < 100; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'(16 + k);
            rd_en   = 1'b1;
            exp_q.push_back(8'(k));
            tick();
            chk("stream_count", 32'(count), 32'd16);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int k = 100; k < 116; k++) pop(8'(k));

        // Reset mid-traffic with wr_en/rd_en active.
        for (int i = 0; i < 10; i++) push(8'h20 + 8'(i));
        chk("pre_reset_count", 32'(count), 32'd10);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        rd_en   = 1'b1;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_reset_state("midrst");
        push(8'h3C);
        push(8'h3D);
        pop(8'h3C);
        pop(8'h3D);
        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
